// File: rtl/keypad_scanner.sv
// Scanner for a 4x4 active-low keypad matrix. It drives one column low at a time
// and debounces both the press and the release on scan ticks. It emits one key/key_valid
// pulse per press, and key_down stays high for as long as the press is held.
// key, key_valid and key_down are registered on the tick that confirms the press.
// As a result, key_valid is high exactly during the single PRESSED state cycle.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PW-1:0] PreMax = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e        state;
  logic [3:0]    row_meta;
  logic [3:0]    rs;
  logic [PW-1:0] pre;
  logic          tick;
  logic [1:0]    col;
  logic [1:0]    row_sel;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    low_row;

  // Map a {row, col} pair to its key code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hD;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hE;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs. It idles at all-released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row_n;
      rs       <= row_meta;
    end
  end

  // Free-running scan prescaler. It produces a one-clk tick at the end of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (pre == PreMax) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick    = (pre == PreMax);
  assign cnt_inc = cnt + 1'b1;
  assign col_n   = ~(4'b0001 << col);

  // Priority pick of the lowest-index row that reads low.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) low_row = 2'(i);
    end
  end

  // Scan / debounce / press / release state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StScan;
      col       <= 2'd0;
      row_sel   <= 2'd0;
      cnt       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        StScan: begin
          if (tick) begin
            if (rs == 4'hF) begin
              col <= col + 2'd1;
            end else begin
              row_sel <= low_row;
              if (DEBOUNCE_CNT == 1) begin
                key       <= key_code(low_row, col);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= '0;
                state     <= StPressed;
              end else begin
                cnt   <= CW'(1);
                state <= StDebounce;
              end
            end
          end
        end
        StDebounce: begin
          if (tick) begin
            if (!rs[row_sel]) begin
              if (cnt_inc == CntMax) begin
                key       <= key_code(row_sel, col);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= '0;
                state     <= StPressed;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Bounce: drop the candidate and move on without a pulse.
              cnt   <= '0;
              col   <= col + 2'd1;
              state <= StScan;
            end
          end
        end
        StPressed: begin
          cnt   <= '0;
          state <= StRelease;
        end
        StRelease: begin
          if (tick) begin
            if (rs == 4'hF) begin
              if (cnt_inc == CntMax) begin
                key_down <= 1'b0;
                cnt      <= '0;
                col      <= col + 2'd1;
                state    <= StScan;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end
        end
        default: state <= StScan;
      endcase
    end
  end

endmodule
